// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the integer register-file write path:
// data width, register address width and load funct3 encodings.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_ext.sv
// Combinational load-data extender: picks the byte/half addressed by offset
// from an aligned word and sign- or zero-extends it according to funct3.
module load_ext
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal written in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        // Halfwords are assumed aligned; offset[0] is ignored.
        half_sel = offset[1] ? word[31:16] : word[15:0];
        data     = word;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = word;
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port driver: merges ALU results and in-order load
// responses into one registered write, and tracks pending load destinations.
module reg_writeback
    import rv_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    output logic                  ld_issue_ready,
    input  logic                  ld_rsp_valid,
    output logic                  ld_rsp_ready,
    input  logic [XLEN-1:0]       ld_rsp_data,
    input  logic [2:0]            ld_rsp_funct3,
    input  logic [1:0]            ld_rsp_offset,
    output logic [REG_ADDR_W-1:0] AddrD,
    output logic [XLEN-1:0]       DataD,
    output logic                  RegWEn,
    output logic [31:0]           busy,
    output logic                  err
);

    localparam int               PTR_W   = $clog2(LQ_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = LQ_DEPTH[PTR_W:0];

    reg_addr_t          q_rd [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] q_vld;
    logic [PTR_W-1:0]   head, tail;
    logic [PTR_W:0]     count;

    logic      full, empty, push, pop;
    reg_addr_t head_rd;
    word_t     ext_data;

    assign full           = (count == DEPTH_C);
    assign empty          = (count == '0);
    assign ld_issue_ready = !full;
    assign ld_rsp_ready   = !alu_valid && !empty;
    assign pop            = ld_rsp_valid && ld_rsp_ready;
    // A full queue still takes an issue when the head is popping in the same
    // cycle: the freed slot is the one the tail reuses.
    assign push           = ld_issue && (!full || pop);
    assign head_rd        = q_rd[head];

    load_ext u_load_ext (
        .word   (ld_rsp_data),
        .funct3 (ld_rsp_funct3),
        .offset (ld_rsp_offset),
        .data   (ext_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            q_vld <= '0;
        end else begin
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            // Later assignment wins, so a full push+pop on one slot stays valid.
            if (push) begin
                q_vld[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the rd storage is left unreset; q_vld alone qualifies each entry,
    // which keeps the array a plain memory.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail] <= ld_issue_rd;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (q_vld[i]) begin
                busy[q_rd[i]] = 1'b1;
            end
        end
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            AddrD  <= '0;
            DataD  <= '0;
            RegWEn <= 1'b0;
            err    <= 1'b0;
        end else begin
            RegWEn <= 1'b0;
            if (alu_valid) begin
                AddrD  <= alu_rd;
                DataD  <= alu_data;
                RegWEn <= (alu_rd != '0);
            end else if (pop) begin
                AddrD  <= head_rd;
                DataD  <= ext_data;
                RegWEn <= (head_rd != '0);
            end
            if (ld_rsp_valid && empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: reset, ALU writes, load extension,
// arbitration, queue full/wrap, duplicate destinations and error flag.
module tb_reg_writeback;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_rsp_valid;
    logic        ld_rsp_ready;
    logic [31:0] ld_rsp_data;
    logic [2:0]  ld_rsp_funct3;
    logic [1:0]  ld_rsp_offset;
    logic [4:0]  AddrD;
    logic [31:0] DataD;
    logic        RegWEn;
    logic [31:0] busy;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_writeback #(.LQ_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_issue       (ld_issue),
        .ld_issue_rd    (ld_issue_rd),
        .ld_issue_ready (ld_issue_ready),
        .ld_rsp_valid   (ld_rsp_valid),
        .ld_rsp_ready   (ld_rsp_ready),
        .ld_rsp_data    (ld_rsp_data),
        .ld_rsp_funct3  (ld_rsp_funct3),
        .ld_rsp_offset  (ld_rsp_offset),
        .AddrD          (AddrD),
        .DataD          (DataD),
        .RegWEn         (RegWEn),
        .busy           (busy),
        .err            (err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ext_f3  [6] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW, F3_LH};
    logic [1:0]  ext_off [6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3};
    logic [31:0] ext_exp [6] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01, 32'hFFFF_80FF};

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; ld_rsp_valid = 1'b0;
        ld_rsp_data = '0; ld_rsp_funct3 = '0; ld_rsp_offset = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_regwen", RegWEn, 0);
        check("rst_addrd", AddrD, 0);
        check("rst_datad", DataD, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_issue_ready", ld_issue_ready, 1);
        check("rst_rsp_ready", ld_rsp_ready, 0);

        // ALU write, one-cycle pulse, then hold
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        tick();
        alu_valid = 1'b0;
        check("alu_regwen", RegWEn, 1);
        check("alu_addrd", AddrD, 5);
        check("alu_datad", DataD, 32'hDEAD_BEEF);
        tick();
        check("alu_regwen_drop", RegWEn, 0);
        check("alu_addrd_hold", AddrD, 5);
        check("alu_datad_hold", DataD, 32'hDEAD_BEEF);
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        tick();
        alu_valid = 1'b0;
        check("alu_rd0_regwen", RegWEn, 0);

        // Load extension cases, each through a single-entry queue to rd 7
        for (int i = 0; i < 6; i++) begin
            ld_issue = 1'b1; ld_issue_rd = 5'd7;
            tick();
            ld_issue = 1'b0;
            check("ext_busy_set", busy, 32'h0000_0080);
            ld_rsp_valid = 1'b1; ld_rsp_data = 32'h80FF_7F01;
            ld_rsp_funct3 = ext_f3[i]; ld_rsp_offset = ext_off[i];
            #1;
            check("ext_rsp_ready", ld_rsp_ready, 1);
            tick();
            ld_rsp_valid = 1'b0;
            check("ext_regwen", RegWEn, 1);
            check("ext_addrd", AddrD, 7);
            check("ext_datad", DataD, ext_exp[i]);
            check("ext_busy_clr", busy, 0);
        end

        // ALU and load response in the same cycle
        ld_issue = 1'b1; ld_issue_rd = 5'd10;
        tick();
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h1111_1111;
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h2222_2222; ld_rsp_funct3 = F3_LW; ld_rsp_offset = 2'd0;
        #1;
        check("arb_rsp_blocked", ld_rsp_ready, 0);
        tick();
        alu_valid = 1'b0;
        #1;
        check("arb_alu_addrd", AddrD, 11);
        check("arb_alu_datad", DataD, 32'h1111_1111);
        check("arb_rsp_ready", ld_rsp_ready, 1);
        tick();
        ld_rsp_valid = 1'b0;
        check("arb_ld_regwen", RegWEn, 1);
        check("arb_ld_addrd", AddrD, 10);
        check("arb_ld_datad", DataD, 32'h2222_2222);
        tick();
        check("arb_idle_regwen", RegWEn, 0);

        // Fill the queue, drop an extra issue, then push+pop across the wrap
        for (int r = 1; r <= 4; r++) begin
            ld_issue = 1'b1; ld_issue_rd = 5'(r);
            tick();
        end
        check("full_issue_ready", ld_issue_ready, 0);
        check("full_busy", busy, 32'h0000_001E);
        ld_issue_rd = 5'd20;
        tick();
        check("full_drop_busy", busy, 32'h0000_001E);
        check("full_drop_regwen", RegWEn, 0);
        ld_rsp_valid = 1'b1; ld_rsp_funct3 = F3_LW;
        ld_issue_rd = 5'd21; ld_rsp_data = 32'h1000_0001;
        tick();
        check("pp_addrd", AddrD, 1);
        check("pp_datad", DataD, 32'h1000_0001);
        check("pp_issue_ready", ld_issue_ready, 0);
        check("pp_busy", busy, 32'h0020_001C);
        for (int k = 0; k < 8; k++) begin
            automatic logic [4:0] exp_rd = (k < 3) ? 5'(k + 2) : 5'(k + 18);
            ld_issue_rd = 5'(22 + k); ld_rsp_data = 32'h1000_0010 + 32'(k);
            tick();
            check("wrap_addrd", AddrD, exp_rd);
            check("wrap_datad", DataD, 32'h1000_0010 + 32'(k));
            check("wrap_issue_ready", ld_issue_ready, 0);
        end
        ld_issue = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drain_addrd", AddrD, 26 + k);
        end
        ld_rsp_valid = 1'b0;
        check("drain_issue_ready", ld_issue_ready, 1);
        check("drain_busy", busy, 0);

        // Duplicate destination
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick();
        tick();
        ld_issue = 1'b0;
        check("dup_busy", busy, 32'h0000_0200);
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0000_0009;
        tick();
        ld_rsp_valid = 1'b0;
        check("dup_busy_first_pop", busy, 32'h0000_0200);
        ld_rsp_valid = 1'b1;
        tick();
        ld_rsp_valid = 1'b0;
        check("dup_busy_second_pop", busy, 0);
        check("dup_addrd", AddrD, 9);

        // Load to rd 0 occupies an entry but never writes
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        tick();
        ld_issue = 1'b0;
        check("rd0_busy", busy, 0);
        check("rd0_rsp_ready", ld_rsp_ready, 1);
        ld_rsp_valid = 1'b1;
        tick();
        ld_rsp_valid = 1'b0;
        check("rd0_regwen", RegWEn, 0);
        check("rd0_rsp_ready_after", ld_rsp_ready, 0);
        check("rd0_err", err, 0);

        // Reset with the queue half full; a stale response then flags err
        ld_issue = 1'b1; ld_issue_rd = 5'd3;
        tick();
        ld_issue_rd = 5'd6;
        tick();
        ld_issue = 1'b0;
        check("mid_busy", busy, 32'h0000_0048);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_issue_ready", ld_issue_ready, 1);
        check("mid_rst_addrd", AddrD, 0);
        check("mid_rst_datad", DataD, 0);
        check("mid_rst_regwen", RegWEn, 0);
        check("mid_rst_err", err, 0);
        ld_rsp_valid = 1'b1;
        tick();
        ld_rsp_valid = 1'b0;
        check("stale_err", err, 1);
        check("stale_regwen", RegWEn, 0);
        tick();
        check("err_sticky", err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
